// File: rtl/cc_pkg.sv
// Shared constants and types for the convolution post-processor.
package cc_pkg;

  localparam int unsigned SampleW  = 19;  // convolution result width
  localparam int unsigned OutW     = 8;   // normalized output width
  localparam int unsigned MaxLen   = 17;  // longest convolution result
  localparam int unsigned ShiftW   = 4;   // width of the SHIFT output
  localparam int unsigned MaxShift = 11;  // largest shift ever needed for SampleW -> OutW

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StNorm,
    StOutput
  } state_e;

endpackage

// File: rtl/cc_sample_buf.sv
// Burst sample storage: Depth x SampleW registers, one write port, one async read port.
// Contents are not reset; every location is written before it is read.
module cc_sample_buf
  import cc_pkg::*;
#(
  parameter int unsigned Depth = MaxLen,
  parameter int unsigned AddrW = $clog2(Depth + 1)
) (
  input  logic                      clk_i,
  input  logic                      we_i,
  input  logic [AddrW-1:0]          waddr_i,
  input  logic signed [SampleW-1:0] wdata_i,
  input  logic [AddrW-1:0]          raddr_i,
  output logic signed [SampleW-1:0] rdata_o
);

  logic signed [SampleW-1:0] mem_q [Depth];

  // Single write port, no reset on the storage array.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cc_postproc.sv
// Convolution post-processor: buffers a burst, picks the smallest arithmetic right shift that
// fits every sample into 8 signed bits, then replays the burst normalized by that shift.
// Optional feature macro: POSTPROC_ROUND_EN (round-half-up before shifting, saturate to 8 bits).
module cc_postproc
  import cc_pkg::*;
#(
  parameter int unsigned MAX_LEN = MaxLen
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      in_valid_i,
  input  logic signed [SampleW-1:0] in_i,
  output logic                      out_valid_o,
  output logic signed [OutW-1:0]    out_o,
  output logic [ShiftW-1:0]         shift_o
);

  localparam int unsigned CntW = $clog2(MAX_LEN + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_LEN);
  localparam logic signed [SampleW-1:0] FitMax = SampleW'(127);
  localparam logic signed [SampleW-1:0] FitMin = -SampleW'(128);

  state_e state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] rd_idx_q, rd_idx_d;
  logic signed [SampleW-1:0] max_q, max_d, min_q, min_d;
  logic [ShiftW-1:0] shift_q, shift_d, shift_sel;

  logic                      buf_we;
  logic [CntW-1:0]           buf_waddr;
  logic signed [SampleW-1:0] rd_data;
  logic signed [OutW-1:0]    out_val;

  cc_sample_buf #(
    .Depth (MAX_LEN),
    .AddrW (CntW)
  ) u_buf (
    .clk_i   (clk_i),
    .we_i    (buf_we),
    .waddr_i (buf_waddr),
    .wdata_i (in_i),
    .raddr_i (rd_idx_q),
    .rdata_o (rd_data)
  );

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      count_q  <= '0;
      rd_idx_q <= '0;
      max_q    <= '0;
      min_q    <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_idx_q <= rd_idx_d;
      max_q    <= max_d;
      min_q    <= min_d;
      shift_q  <= shift_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (in_valid_i) state_d = StLoad;
      StLoad:   if (!in_valid_i) state_d = StNorm;
      StNorm:   state_d = StOutput;
      StOutput: if (rd_idx_q == count_q - CntW'(1)) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Smallest shift that fits both extremes; scanning downward leaves the smallest fitting one.
  always_comb begin
    shift_sel = ShiftW'(MaxShift);
    for (int s = int'(MaxShift); s >= 0; s--) begin
      if ((max_q >>> s) <= FitMax && (min_q >>> s) >= FitMin) begin
        shift_sel = ShiftW'(s);
      end
    end
  end

  // Datapath next-state: capture, running extremes, shift latch, read pointer.
  always_comb begin
    count_d   = count_q;
    rd_idx_d  = rd_idx_q;
    max_d     = max_q;
    min_d     = min_q;
    shift_d   = shift_q;
    buf_we    = 1'b0;
    buf_waddr = count_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          buf_we    = 1'b1;
          buf_waddr = '0;
          count_d   = CntW'(1);
          rd_idx_d  = '0;
          max_d     = in_i;
          min_d     = in_i;
        end
      end
      StLoad: begin
        // Samples beyond MAX_LEN are dropped and do not affect the extremes.
        if (in_valid_i && count_q < MaxCnt) begin
          buf_we  = 1'b1;
          count_d = count_q + CntW'(1);
          if (in_i > max_q) max_d = in_i;
          if (in_i < min_q) min_d = in_i;
        end
      end
      StNorm:   shift_d  = shift_sel;
      StOutput: rd_idx_d = rd_idx_q + CntW'(1);
      default: ;
    endcase
  end

`ifdef POSTPROC_ROUND_EN
  localparam logic signed [SampleW:0] SatMax = (SampleW + 1)'(127);
  localparam logic signed [SampleW:0] SatMin = -(SampleW + 1)'(128);
  logic signed [SampleW:0] rnd_sum, rnd_shr;

  // Round half up, then saturate to the output range.
  always_comb begin
    rnd_sum = {rd_data[SampleW-1], rd_data};
    if (shift_q != '0) begin
      rnd_sum = rnd_sum + ((SampleW + 1)'(1) << (shift_q - ShiftW'(1)));
    end
    rnd_shr = rnd_sum >>> shift_q;
    if (rnd_shr > SatMax) begin
      out_val = OutW'(127);
    end else if (rnd_shr < SatMin) begin
      out_val = -OutW'(128);
    end else begin
      out_val = OutW'(rnd_shr);
    end
  end
`else
  // Floor shift; the chosen shift guarantees the result fits in OutW bits.
  always_comb begin
    out_val = OutW'(rd_data >>> shift_q);
  end
`endif

  // Outputs are forced to zero outside the replay window.
  always_comb begin
    out_valid_o = (state_q == StOutput);
    out_o       = out_valid_o ? out_val : '0;
    shift_o     = out_valid_o ? shift_q : '0;
  end

endmodule

// File: tb/tb_cc_postproc.sv
// Directed self-checking bench for cc_postproc (expectations follow POSTPROC_ROUND_EN).
module tb_cc_postproc;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              in_valid_i = 1'b0;
  logic signed [18:0] in_i = '0;
  logic              out_valid_o;
  logic signed [7:0] out_o;
  logic [3:0]        shift_o;

  int n_checks = 0;
  int n_errors = 0;

  cc_postproc dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_i        (in_i),
    .out_valid_o (out_valid_o),
    .out_o       (out_o),
    .shift_o     (shift_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a burst at negedges, then check latency, replay and return to idle.
  // With pulse set, IN_VALID is held high from NORM through the end of OUTPUT.
  task automatic run_burst(input string name, input int vals[$], input int exp_shift,
                           input int exp_out[$], input bit pulse);
    foreach (vals[i]) begin
      @(negedge clk_i);
      in_valid_i = 1'b1;
      in_i       = 19'(vals[i]);
    end
    @(negedge clk_i);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    check({name, ".norm_ov"}, int'(out_valid_o), 0);
    in_valid_i = pulse;
    in_i       = 19'(99);
    foreach (exp_out[k]) begin
      @(negedge clk_i);
      check($sformatf("%s.ov[%0d]", name, k), int'(out_valid_o), 1);
      check($sformatf("%s.shift[%0d]", name, k), int'(shift_o), exp_shift);
      check($sformatf("%s.out[%0d]", name, k), int'(out_o), exp_out[k]);
    end
    @(negedge clk_i);
    check({name, ".end_ov"}, int'(out_valid_o), 0);
    check({name, ".end_out"}, int'(out_o), 0);
    check({name, ".end_shift"}, int'(shift_o), 0);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    check({name, ".idle_ov"}, int'(out_valid_o), 0);
  endtask

  initial begin
    int ones[$];
    int ones_out[$];

    #1;
    check("rst.ov", int'(out_valid_o), 0);
    check("rst.out", int'(out_o), 0);
    check("rst.shift", int'(shift_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    run_burst("b3", '{100, -50, 7}, 0, '{100, -50, 7}, 1'b0);
    run_burst("ext", '{262143, -262144}, 11, '{127, -128}, 1'b0);
`ifdef POSTPROC_ROUND_EN
    run_burst("s3", '{1000, -3}, 3, '{125, 0}, 1'b0);
`else
    run_burst("s3", '{1000, -3}, 3, '{125, -1}, 1'b0);
`endif
    run_burst("s1", '{255}, 1, '{127}, 1'b0);

    for (int i = 0; i < 20; i++) ones.push_back(1);
    for (int i = 0; i < 17; i++) ones_out.push_back(1);
    run_burst("sat", ones, 0, ones_out, 1'b0);

    run_burst("ign", '{5, 5}, 0, '{5, 5}, 1'b1);

    // Reset during OUTPUT.
    @(negedge clk_i); in_valid_i = 1'b1; in_i = 19'(300);
    @(negedge clk_i); in_i = 19'(-300);
    @(negedge clk_i); in_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("mid.ov", int'(out_valid_o), 1);
    check("mid.shift", int'(shift_o), 2);
    check("mid.out", int'(out_o), 75);
    rst_ni = 1'b0;
    #1;
    check("mid_rst.ov", int'(out_valid_o), 0);
    check("mid_rst.out", int'(out_o), 0);
    check("mid_rst.shift", int'(shift_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_rst.ov", int'(out_valid_o), 0);
    run_burst("neg1", '{-1}, 0, '{-1}, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cc_postproc.md
CC_POSTPROC -- requirements
Module: cc_postproc

Interface
REQ-001 Parameter MAX_LEN, default 17: maximum stored burst length, equal to the longest convolution result.
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 RESET  input  1  reset, asynchronous and active-low.
REQ-004 IN_VALID  input  1  high while IN carries a convolution result sample; contiguous burst.
REQ-005 IN  input  19 signed  convolution result sample.
REQ-006 OUT_VALID  output  1  high while OUT/SHIFT carry normalized samples.
REQ-007 OUT  output  8 signed  normalized sample.
REQ-008 SHIFT  output  4  arithmetic right-shift applied to the current burst, 0..11.

Function
REQ-009 The block SHALL use four states: IDLE, LOAD, NORM, OUTPUT.
REQ-010 IDLE->LOAD on IN_VALID=1; that sample is stored as sample 0, and running max/min are initialized to it.
REQ-011 LOAD: each IN_VALID=1 cycle stores IN at index count, updates max/min, and increments count; count saturates at MAX_LEN, and excess samples are dropped and excluded from max/min.
REQ-012 LOAD->NORM on first IN_VALID=0; NORM lasts exactly one cycle, then OUTPUT.
REQ-013 NORM SHALL register SHIFT = smallest s in 0..11 with (max>>>s)<=127 and (min>>>s)>=-128.
REQ-014 OUTPUT: OUT_VALID=1 for exactly count consecutive cycles; OUT = sample[k]>>>SHIFT (arithmetic, floor) for k=0..count-1, in input order.
REQ-015 Latency: first OUT_VALID rises on the second rising edge after the edge capturing the last valid sample.
REQ-016 OUTPUT->IDLE after the last sample; IDLE may accept a new burst on the next edge.
REQ-017 IN_VALID during NORM or OUTPUT SHALL be ignored (nothing stored, no state effect).
REQ-018 When OUT_VALID=0, OUT=0 and SHIFT=0.

Reset
REQ-019 RESET low SHALL immediately force state IDLE, count 0, OUT_VALID 0, OUT 0, SHIFT 0, max/min 0.
REQ-020 Sample storage need not be cleared.
REQ-021 Reset mid-burst or mid-OUTPUT aborts it; no further OUT_VALID for that burst.

Configuration
REQ-022 With POSTPROC_ROUND_EN defined: OUT = (sample + 2^(SHIFT-1))>>>SHIFT for SHIFT>0, saturated to [-128,127]; SHIFT selection unchanged.
REQ-023 Without POSTPROC_ROUND_EN: truncating floor shift per REQ-014, and no rounding adder is built.

Structure
REQ-024 Shared package cc_pkg SHALL hold the sample width (19), output width (8), MAX_LEN, the SHIFT width, and the state enum.
REQ-025 Storage SHALL be a sub-module cc_sample_buf (MAX_LEN x 19 registers, one write port, one async read port).
REQ-026 Shift selection and the output datapath stay in cc_postproc.

Verification
REQ-027 Burst {100,-50,7} -> SHIFT=0; OUT 100,-50,7 on 3 consecutive OUT_VALID cycles, starting 2 edges after the last sample.
REQ-028 Burst {262143,-262144} -> SHIFT=11; OUT 127,-128.
REQ-029 Burst {1000,-3} -> SHIFT=3; OUT 125,-1 (round build: 125,0). Burst {255} -> SHIFT=1; OUT 127 (round build: saturated 127).
REQ-030 20-cycle burst of value 1 -> exactly 17 OUT_VALID cycles, OUT=1, SHIFT=0.
REQ-031 Burst {5,5} with IN_VALID pulsed during OUTPUT -> outputs unaffected; the block returns to IDLE after 2 outputs.
REQ-032 RESET low mid-OUTPUT -> OUT_VALID, OUT and SHIFT read 0 before the next edge; a following burst {-1} -> SHIFT=0, OUT -1.
